axi_id_push_ctrl: RTL and testbench
===================================

# axi_id_push_ctrl

AXI-side (wclk domain) producer for the 16-entry, 9-bit ID FIFO of the AXI-to-AHB bridge. It arbitrates between the AXI AW and AR address channels and packs each accepted request into a 9-bit ID entry. It buffers that entry in a one-deep holding register and pushes it into the FIFO write port, respecting fifo_full. It also tracks outstanding transactions against a programmable limit, so the bridge never has more IDs in flight than the return path can retire.

## Interface
Parameters:
- MAX_OUT, 16, maximum outstanding transactions (accepted, not yet retired); legal range 1..31.

Ports:
- wclk  in  1  AXI-side clock; all logic on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- aw_valid  in  1  AXI write address valid.
- aw_ready  out  1  AXI write address ready.
- aw_id  in  4  AXI write ID.
- aw_len  in  4  AXI write burst length (beats − 1).
- ar_valid  in  1  AXI read address valid.
- ar_ready  out  1  AXI read address ready.
- ar_id  in  4  AXI read ID.
- ar_len  in  4  AXI read burst length (beats − 1).
- fifo_data  out  9  entry to FIFO data_in: {dir, id[3:0], len[3:0]}, where dir = 1 for write and 0 for read.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag (wclk domain).
- txn_done  in  1  single-cycle pulse, one transaction retired (already synchronised into wclk).
- outstanding  out  5  current outstanding count.
- err_underflow  out  1  sticky; txn_done received while outstanding == 0.

## Operation
- Holding register: hold_valid and hold_data[8:0]; fifo_data = hold_data.
- fifo_wr_en = hold_valid & !fifo_full. A write (drain) occurs when fifo_wr_en = 1.
- can_accept = (!hold_valid | drain) & (outstanding < MAX_OUT).
- Arbitration is round-robin using a 1-bit prio (0 = AW preferred, 1 = AR preferred).
  - aw_win = aw_valid & (!ar_valid | prio == 0).
  - ar_win = ar_valid & (!aw_valid | prio == 1).
  - aw_ready = can_accept & aw_win; ar_ready = can_accept & ar_win. These are combinational.
  - At most one ready is high per cycle.
- On an AW handshake: hold_data ← {1, aw_id, aw_len}, hold_valid ← 1, prio ← 1.
- On an AR handshake: hold_data ← {0, ar_id, ar_len}, hold_valid ← 1, prio ← 0.
- prio changes only on a handshake. An idle or stalled cycle leaves it unchanged.
- Drain without a new handshake: hold_valid ← 0; hold_data keeps its value.
- outstanding:
  - +1 per handshake, −1 per txn_done.
  - A handshake and txn_done in the same cycle leave it unchanged.
  - Never exceeds MAX_OUT and never wraps below 0.
- txn_done while outstanding == 0 and no handshake in the same cycle: outstanding stays 0 and err_underflow ← 1. The flag clears only on reset.
- txn_done while outstanding == 0 together with a handshake: the net count is 0 and there is no error.

## Timing
- Reset values: aw_ready = 0, ar_ready = 0, fifo_wr_en = 0, fifo_data = 0, outstanding = 0, err_underflow = 0, hold_valid = 0, prio = 0.
  - aw_ready and ar_ready may rise in the first cycle after reset is released if the corresponding valid is high.
- Latency: a handshake at edge N gives fifo_wr_en = 1 during cycle N+1 (if !fifo_full). The FIFO write occurs at edge N+1.
- Throughput: one entry per cycle sustained while fifo_full = 0 and outstanding < MAX_OUT. Draining and accepting happen on the same edge.
- fifo_full high: the entry is held and fifo_data is stable. Ready is deasserted until the full flag drops, since the holding register is occupied.
- Limit reached (outstanding == MAX_OUT): both readies are 0 even if the holding register is empty. A txn_done at edge N re-enables ready in cycle N+1.
- AXI rule: the block never withdraws a ready that was issued in a given cycle. A valid/ready pair sampled high at the edge is a completed handshake.
- Reset asserted mid-operation: all state returns to reset values immediately, the held entry is discarded, and fifo_wr_en drops asynchronously.

## Test plan
- Single AW: aw_id = 4'h5, aw_len = 4'h3, fifo_full = 0 → aw_ready = 1 in the same cycle. fifo_data = 9'h153 with fifo_wr_en = 1 in the next cycle. outstanding = 1.
- Both valid for 4 cycles (aw_id = 1, ar_id = 2, len = 0) → grants alternate AW, AR, AW, AR. FIFO receives 9'h110, 9'h020, 9'h110, 9'h020 on consecutive cycles.
- fifo_full held high for 5 cycles after one AW → fifo_wr_en = 0 and fifo_data constant, both readies 0. The entry is written in the first cycle after full drops.
- MAX_OUT = 2 with 3 back-to-back ARs and no txn_done → 2 accepted, third ar_ready = 0. One txn_done pulse → third accepted next cycle; outstanding reads 2.
- txn_done pulse with outstanding = 0 → err_underflow = 1 and stays 1; outstanding stays 0. Reset clears it.
- Reset pulse while an entry is held and fifo_full = 1 → fifo_wr_en = 0, outstanding = 0, and no stale write after reset release.

Source files
------------

// File: rtl/axi_id_push_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_id_push_ctrl
// Brief    : AW/AR round-robin arbiter that packs requests into 9-bit ID-FIFO entries.
// Revision : 1.0
// ============================================================================
module axi_id_push_ctrl #(
  parameter int MAX_OUT = 16
) (
  input  logic       wclk,
  input  logic       resetn,
  input  logic       aw_valid,
  output logic       aw_ready,
  input  logic [3:0] aw_id,
  input  logic [3:0] aw_len,
  input  logic       ar_valid,
  output logic       ar_ready,
  input  logic [3:0] ar_id,
  input  logic [3:0] ar_len,
  output logic [8:0] fifo_data,
  output logic       fifo_wr_en,
  input  logic       fifo_full,
  input  logic       txn_done,
  output logic [4:0] outstanding,
  output logic       err_underflow
);

  localparam logic [4:0] C_MAX_OUT = 5'(MAX_OUT);

  logic       hold_valid_q, hold_valid_d;
  logic [8:0] hold_data_q,  hold_data_d;
  logic       prio_q,       prio_d;
  logic [4:0] out_q,        out_d;
  logic       err_q,        err_d;

  logic w_drain;
  logic w_can_accept;
  logic w_aw_win;
  logic w_ar_win;
  logic w_aw_hs;
  logic w_ar_hs;
  logic w_hs;

  // A full holding register may still accept when it drains on the same edge.
  assign w_drain      = hold_valid_q & ~fifo_full;
  assign w_can_accept = (~hold_valid_q | w_drain) & (out_q < C_MAX_OUT);
  assign w_aw_win     = aw_valid & (~ar_valid | ~prio_q);
  assign w_ar_win     = ar_valid & (~aw_valid |  prio_q);

  assign aw_ready = w_can_accept & w_aw_win;
  assign ar_ready = w_can_accept & w_ar_win;
  assign w_aw_hs  = aw_valid & aw_ready;
  assign w_ar_hs  = ar_valid & ar_ready;
  assign w_hs     = w_aw_hs | w_ar_hs;

  assign fifo_data     = hold_data_q;
  assign fifo_wr_en    = w_drain;
  assign outstanding   = out_q;
  assign err_underflow = err_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    prio_d       = prio_q;
    out_d        = out_q;
    err_d        = err_q;

    if (w_aw_hs) begin
      hold_data_d  = {1'b1, aw_id, aw_len};
      hold_valid_d = 1'b1;
      prio_d       = 1'b1;
    end else if (w_ar_hs) begin
      hold_data_d  = {1'b0, ar_id, ar_len};
      hold_valid_d = 1'b1;
      prio_d       = 1'b0;
    end else if (w_drain) begin
      hold_valid_d = 1'b0;
    end

    // A retirement alongside a handshake nets to zero, even from an empty count.
    if (w_hs && !txn_done) begin
      out_d = out_q + 5'd1;
    end else if (!w_hs && txn_done) begin
      if (out_q != 5'd0) begin
        out_d = out_q - 5'd1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= 9'd0;
      prio_q       <= 1'b0;
      out_q        <= 5'd0;
      err_q        <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      prio_q       <= prio_d;
      out_q        <= out_d;
      err_q        <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_id_push_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_id_push_ctrl
// Brief    : Vector table, directed corner sequences and randomized model check.
// Revision : 1.0
// ============================================================================
module tb_axi_id_push_ctrl;

  localparam int C_MAX_OUT = 2;

  logic       wclk = 1'b0;
  logic       resetn;
  logic       aw_valid, ar_valid, fifo_full, txn_done;
  logic [3:0] aw_id, aw_len, ar_id, ar_len;
  logic       aw_ready, ar_ready, fifo_wr_en, err_underflow;
  logic [8:0] fifo_data;
  logic [4:0] outstanding;

  int n_chk  = 0;
  int n_pass = 0;

  axi_id_push_ctrl #(.MAX_OUT(C_MAX_OUT)) u_dut (
    .wclk          (wclk),
    .resetn        (resetn),
    .aw_valid      (aw_valid),
    .aw_ready      (aw_ready),
    .aw_id         (aw_id),
    .aw_len        (aw_len),
    .ar_valid      (ar_valid),
    .ar_ready      (ar_ready),
    .ar_id         (ar_id),
    .ar_len        (ar_len),
    .fifo_data     (fifo_data),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_full     (fifo_full),
    .txn_done      (txn_done),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       awv;
    logic [3:0] awid;
    logic [3:0] awlen;
    logic       arv;
    logic [3:0] arid;
    logic [3:0] arlen;
    logic       full;
    logic       txn;
    logic       e_awr;
    logic       e_arr;
    logic       e_wr;
    logic [8:0] e_data;
    logic [4:0] e_out;
    logic       e_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic drive(input logic awv, input logic [3:0] awi, input logic [3:0] awl,
                       input logic arv, input logic [3:0] ari, input logic [3:0] arl,
                       input logic full, input logic txn);
    aw_valid = awv; aw_id = awi; aw_len = awl;
    ar_valid = arv; ar_id = ari; ar_len = arl;
    fifo_full = full; txn_done = txn;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    repeat (2) @(posedge wclk);
    #1 resetn = 1'b1;
  endtask

  // Reference model state for the randomized phase
  bit         m_hv;
  logic [8:0] m_data;
  bit         m_prio;
  bit         m_err;
  int         m_cnt;

  initial begin
    bit drain, room, pick_aw, pick_ar, e_awr, e_arr, acc;

    // {awv,awid,awlen, arv,arid,arlen, full,txn | awr,arr,wr,data,out,err}
    vecs[0]  = '{0,0,0, 0,0,0, 0,0, 0,0,0,9'h000,0,0};
    vecs[1]  = '{1,1,0, 1,2,0, 0,0, 1,0,0,9'h000,0,0};
    vecs[2]  = '{1,1,0, 1,2,0, 0,1, 0,1,1,9'h110,1,0};
    vecs[3]  = '{1,1,0, 1,2,0, 0,1, 1,0,1,9'h020,1,0};
    vecs[4]  = '{1,1,0, 1,2,0, 0,1, 0,1,1,9'h110,1,0};
    vecs[5]  = '{0,0,0, 0,0,0, 0,0, 0,0,1,9'h020,1,0};
    vecs[6]  = '{0,0,0, 0,0,0, 0,1, 0,0,0,9'h020,1,0};
    vecs[7]  = '{1,5,3, 0,0,0, 0,0, 1,0,0,9'h020,0,0};
    vecs[8]  = '{0,0,0, 0,0,0, 0,0, 0,0,1,9'h153,1,0};
    vecs[9]  = '{0,0,0, 0,0,0, 0,1, 0,0,0,9'h153,1,0};
    vecs[10] = '{0,0,0, 1,3,7, 0,1, 0,1,0,9'h153,0,0};
    vecs[11] = '{0,0,0, 0,0,0, 0,0, 0,0,1,9'h037,0,0};
    vecs[12] = '{0,0,0, 0,0,0, 0,1, 0,0,0,9'h037,0,0};
    vecs[13] = '{0,0,0, 0,0,0, 0,0, 0,0,0,9'h037,0,1};

    do_reset();

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].awv, vecs[i].awid, vecs[i].awlen, vecs[i].arv, vecs[i].arid,
            vecs[i].arlen, vecs[i].full, vecs[i].txn);
      #4;
      chk($sformatf("vec%0d aw_ready", i), 32'(aw_ready), 32'(vecs[i].e_awr));
      chk($sformatf("vec%0d ar_ready", i), 32'(ar_ready), 32'(vecs[i].e_arr));
      chk($sformatf("vec%0d wr_en", i), 32'(fifo_wr_en), 32'(vecs[i].e_wr));
      chk($sformatf("vec%0d data", i), 32'(fifo_data), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d outstanding", i), 32'(outstanding), 32'(vecs[i].e_out));
      chk($sformatf("vec%0d err", i), 32'(err_underflow), 32'(vecs[i].e_err));
      tick();
    end

    // Sticky error clears only through reset
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4 chk("err still set", 32'(err_underflow), 32'd1);
    do_reset();
    #4 chk("err cleared by reset", 32'(err_underflow), 32'd0);
    tick();

    // FIFO full stall: entry held, readies low, written once full drops
    drive(1, 5, 3, 0, 0, 0, 0, 0);
    #4 chk("full aw_ready first", 32'(aw_ready), 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 6, 6, 0, 0, 0, 1, 0);
      #4;
      chk("full aw_ready", 32'(aw_ready), 32'd0);
      chk("full wr_en", 32'(fifo_wr_en), 32'd0);
      chk("full data", 32'(fifo_data), 32'h153);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("unfull wr_en", 32'(fifo_wr_en), 32'd1);
    chk("unfull data", 32'(fifo_data), 32'h153);
    tick();
    #4 chk("drained wr_en", 32'(fifo_wr_en), 32'd0);

    // Outstanding limit with three back-to-back ARs
    do_reset();
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    #4 chk("lim ar1 ready", 32'(ar_ready), 32'd1);
    tick();
    drive(0, 0, 0, 1, 2, 0, 0, 0);
    #4 chk("lim ar2 ready", 32'(ar_ready), 32'd1);
    tick();
    drive(0, 0, 0, 1, 3, 0, 0, 0);
    #4;
    chk("lim ar3 blocked", 32'(ar_ready), 32'd0);
    chk("lim out at max", 32'(outstanding), 32'd2);
    chk("lim wr ar2", 32'(fifo_data), 32'h020);
    tick();
    drive(0, 0, 0, 1, 3, 0, 0, 1);
    #4 chk("lim blocked during done", 32'(ar_ready), 32'd0);
    tick();
    drive(0, 0, 0, 1, 3, 0, 0, 0);
    #4 chk("lim ar3 accepted", 32'(ar_ready), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("lim out after", 32'(outstanding), 32'd2);
    chk("lim data ar3", 32'(fifo_data), 32'h030);
    chk("lim wr ar3", 32'(fifo_wr_en), 32'd1);

    // Asynchronous reset with an entry held behind fifo_full
    do_reset();
    drive(1, 9, 9, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    fifo_full = 1'b0;
    #2 chk("rst pre wr_en", 32'(fifo_wr_en), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst async wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst async out", 32'(outstanding), 32'd0);
    chk("rst async data", 32'(fifo_data), 32'd0);
    @(posedge wclk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4 chk("rst no stale write", 32'(fifo_wr_en), 32'd0);
      tick();
    end

    // Randomized traffic against the reference model
    do_reset();
    m_hv = 0; m_data = '0; m_prio = 0; m_err = 0; m_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 9) < 6), 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 9) < 6), 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < (i < 300 ? 3 : 5)));
      #4;
      drain   = m_hv && !fifo_full;
      room    = (!m_hv || drain) && (m_cnt < C_MAX_OUT);
      pick_aw = aw_valid && (!ar_valid || !m_prio);
      pick_ar = ar_valid && (!aw_valid || m_prio);
      e_awr   = room && pick_aw;
      e_arr   = room && pick_ar;
      chk("rnd aw_ready", 32'(aw_ready), 32'(e_awr));
      chk("rnd ar_ready", 32'(ar_ready), 32'(e_arr));
      chk("rnd wr_en", 32'(fifo_wr_en), 32'(drain));
      chk("rnd data", 32'(fifo_data), 32'(m_data));
      chk("rnd outstanding", 32'(outstanding), 32'(m_cnt));
      chk("rnd err", 32'(err_underflow), 32'(m_err));
      if (e_awr) begin
        m_data = {1'b1, aw_id, aw_len}; m_hv = 1; m_prio = 1;
      end else if (e_arr) begin
        m_data = {1'b0, ar_id, ar_len}; m_hv = 1; m_prio = 0;
      end else if (drain) begin
        m_hv = 0;
      end
      acc = e_awr || e_arr;
      if (acc && !txn_done) m_cnt++;
      else if (!acc && txn_done) begin
        if (m_cnt == 0) m_err = 1;
        else m_cnt--;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
